ascon_init_loader: RTL

Front-end loader and finaliser for the Ascon-128 initialisation permutation stage. Accepts the 128-bit key and 128-bit nonce as eight 32-bit words over a valid/ready stream and assembles the initial 320-bit state IV‖K‖N. It launches the 12-round init stage, captures the permuted state it streams back, and applies the final key XOR to x3/x4. The finalised state and key are then presented to the downstream associated-data/encryption stage over a valid/ready handshake.

---
 rtl/ascon_init_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/ascon_init_loader.sv
// Ascon-128 init front end: loads key/nonce words, launches the init permutation, key-XORs its result.
// Start pulses the cycle after word 7; out_valid rises the cycle after init_finished_i and holds until out_ready_i.
package ascon_init_loader_pkg;
  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } state_t;
endpackage

module ascon_init_loader
  import ascon_init_loader_pkg::*;
#(
  parameter logic [63:0] IV = 64'h80400c0600000000
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         clear_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [31:0]  in_data_i,
  output logic         init_start_o,
  output state_t       init_state_o,
  input  logic         init_update_i,
  input  state_t       init_state_i,
  input  logic         init_finished_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output state_t       out_state_o,
  output logic [127:0] key_o,
  output logic         busy_o
);

  typedef enum logic [1:0] {LOAD, START, WAIT, OUT} fsm_t;

  fsm_t         fsm;
  logic [2:0]   wcnt;
  logic [127:0] key;
  logic [127:0] nonce;
  state_t       capture;
  logic         word_acc;

  assign word_acc = in_valid_i & in_ready_o;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      fsm          <= LOAD;
      wcnt         <= '0;
      in_ready_o   <= 1'b1;
      init_start_o <= 1'b0;
      out_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
      key          <= '0;
      nonce        <= '0;
      capture      <= '0;
      out_state_o  <= '0;
    end else if (clear_i) begin
      // Abort wins over any handshake this cycle; data registers are left as they are.
      fsm          <= LOAD;
      wcnt         <= '0;
      in_ready_o   <= 1'b1;
      init_start_o <= 1'b0;
      out_valid_o  <= 1'b0;
      busy_o       <= 1'b0;
    end else begin
      case (fsm)
        LOAD: begin
          if (word_acc) begin
            // Word 0 of each half lands in the most significant 32 bits.
            if (wcnt[2]) begin
              nonce[{~wcnt[1:0], 5'd0} +: 32] <= in_data_i;
            end else begin
              key[{~wcnt[1:0], 5'd0} +: 32] <= in_data_i;
            end
            wcnt <= wcnt + 3'd1;
            if (wcnt == 3'd7) begin
              fsm          <= START;
              in_ready_o   <= 1'b0;
              init_start_o <= 1'b1;
              busy_o       <= 1'b1;
            end
          end
        end
        START: begin
          fsm          <= WAIT;
          init_start_o <= 1'b0;
        end
        WAIT: begin
          if (init_update_i) begin
            capture <= init_state_i;
          end
          if (init_finished_i) begin
            out_state_o <= {capture.x0, capture.x1, capture.x2,
                            capture.x3 ^ key[127:64], capture.x4 ^ key[63:0]};
            fsm         <= OUT;
            out_valid_o <= 1'b1;
          end
        end
        OUT: begin
          if (out_ready_i) begin
            fsm         <= LOAD;
            out_valid_o <= 1'b0;
            in_ready_o  <= 1'b1;
            busy_o      <= 1'b0;
          end
        end
        default: fsm <= LOAD;
      endcase
    end
  end

  assign key_o        = key;
  assign init_state_o = {IV, key, nonce};

endmodule
